// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: widths, forward-select
// encodings, multiply/divide opcodes and default unit latencies.
package hazard_pkg;

  localparam int AW = 5;
  localparam int TW = 2;

  // All-ones Tuse marks an operand the instruction never reads.
  localparam logic [TW-1:0] TUSE_NONE = '1;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard query bus: D-stage instruction fields in, stall and
// forward selects out, all resolved combinationally in the same cycle.
interface hazard_if #(
  parameter int AW = hazard_pkg::AW,
  parameter int TW = hazard_pkg::TW
);
  // No valid/ready pair: D fields are sampled every cycle, and stall=1 is the
  // only back-pressure, telling the pipeline to hold PC/D and bubble E.
  logic [AW-1:0] D_rs;
  logic [AW-1:0] D_rt;
  logic [TW-1:0] D_tuse_rs;
  logic [TW-1:0] D_tuse_rt;
  logic [AW-1:0] D_a3;
  logic [TW-1:0] D_tnew;
  logic [1:0]    D_md_start;
  logic          D_md_use;

  logic          stall;
  logic [1:0]    fwd_D_rs;
  logic [1:0]    fwd_D_rt;
  logic [1:0]    fwd_E_rs;
  logic [1:0]    fwd_E_rt;
  logic          md_busy;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_a3, D_tnew, D_md_start, D_md_use,
    input  stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, md_busy
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_a3, D_tnew, D_md_start, D_md_use,
    output stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, md_busy
  );

endinterface

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Multiply/divide occupancy counter: loads the unit latency when a start
// enters E, then counts down to zero; busy is registered.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = hazard_pkg::MUL_LAT_DEF,
  parameter int DIV_LAT = hazard_pkg::DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] start_i,
  input  logic       load_i,
  output logic       busy_o
);

  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;

  always_comb begin
    cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    if (load_i) begin
      if (start_i == MD_MULT) begin
        cnt_d = CW'(MUL_LAT);
      end else if (start_i == MD_DIV) begin
        cnt_d = CW'(DIV_LAT);
      end
    end
  end

  // busy follows the next count so it is a flop, not a decode of cnt_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W destination shadows, raises stall
// on Tuse/Tnew conflicts or a busy md unit, and picks operand forward sources.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW      = hazard_pkg::AW,
  parameter int TW      = hazard_pkg::TW,
  parameter int MUL_LAT = hazard_pkg::MUL_LAT_DEF,
  parameter int DIV_LAT = hazard_pkg::DIV_LAT_DEF
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hif
);

  localparam logic [TW-1:0] TUSE_ALL = '1;

  logic [AW-1:0] e_a3_q, e_a3_d, e_rs_q, e_rs_d, e_rt_q, e_rt_d;
  logic [AW-1:0] m_a3_q, m_a3_d, w_a3_q, w_a3_d;
  logic [TW-1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;
  logic          rs_hz, rt_hz, stall, md_busy;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? t : t - TW'(1);
  endfunction

  function automatic logic raw_hit(input logic [AW-1:0] x, input logic [TW-1:0] tuse,
                                   input logic [AW-1:0] s_a3, input logic [TW-1:0] s_tnew);
    return (s_a3 == x) && (s_tnew > tuse);
  endfunction

  // Youngest matching stage decides; a match not yet ready falls back to regfile.
  function automatic logic [1:0] fwd_pick(input logic [AW-1:0] x,
                                          input logic [AW-1:0] y_a3, input logic [TW-1:0] y_tnew,
                                          input logic [1:0] y_code,
                                          input logic [AW-1:0] o_a3, input logic [TW-1:0] o_tnew,
                                          input logic [1:0] o_code);
    if (y_a3 != '0 && y_a3 == x) begin
      return (y_tnew == '0) ? y_code : FWD_RF;
    end else if (o_a3 != '0 && o_a3 == x) begin
      return (o_tnew == '0) ? o_code : FWD_RF;
    end
    return FWD_RF;
  endfunction

  assign rs_hz = (hif.D_rs != '0) && (hif.D_tuse_rs != TUSE_ALL) &&
                 (raw_hit(hif.D_rs, hif.D_tuse_rs, e_a3_q, e_tnew_q) ||
                  raw_hit(hif.D_rs, hif.D_tuse_rs, m_a3_q, m_tnew_q) ||
                  raw_hit(hif.D_rs, hif.D_tuse_rs, w_a3_q, w_tnew_q));

  assign rt_hz = (hif.D_rt != '0) && (hif.D_tuse_rt != TUSE_ALL) &&
                 (raw_hit(hif.D_rt, hif.D_tuse_rt, e_a3_q, e_tnew_q) ||
                  raw_hit(hif.D_rt, hif.D_tuse_rt, m_a3_q, m_tnew_q) ||
                  raw_hit(hif.D_rt, hif.D_tuse_rt, w_a3_q, w_tnew_q));

  assign stall = rs_hz | rt_hz | (hif.D_md_use & md_busy);

  assign hif.stall    = stall;
  assign hif.md_busy  = md_busy;
  assign hif.fwd_D_rs = fwd_pick(hif.D_rs, e_a3_q, e_tnew_q, FWD_E, m_a3_q, m_tnew_q, FWD_M);
  assign hif.fwd_D_rt = fwd_pick(hif.D_rt, e_a3_q, e_tnew_q, FWD_E, m_a3_q, m_tnew_q, FWD_M);
  assign hif.fwd_E_rs = fwd_pick(e_rs_q, m_a3_q, m_tnew_q, FWD_M, w_a3_q, w_tnew_q, FWD_W);
  assign hif.fwd_E_rt = fwd_pick(e_rt_q, m_a3_q, m_tnew_q, FWD_M, w_a3_q, w_tnew_q, FWD_W);

  always_comb begin
    e_a3_d   = stall ? '0 : hif.D_a3;
    e_tnew_d = stall ? '0 : hif.D_tnew;
    e_rs_d   = stall ? '0 : hif.D_rs;
    e_rt_d   = stall ? '0 : hif.D_rt;
    m_a3_d   = e_a3_q;
    m_tnew_d = dec_sat(e_tnew_q);
    w_a3_d   = m_a3_q;
    w_tnew_d = dec_sat(m_tnew_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_a3_q   <= '0;
      e_tnew_q <= '0;
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      m_a3_q   <= '0;
      m_tnew_q <= '0;
      w_a3_q   <= '0;
      w_tnew_q <= '0;
    end else begin
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      w_a3_q   <= w_a3_d;
      w_tnew_q <= w_tnew_d;
    end
  end

  md_busy_counter #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy_counter (
    .clk     (clk),
    .reset   (reset),
    .start_i (hif.D_md_start),
    .load_i  (!stall),
    .busy_o  (md_busy)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed stall/forward/md-busy values
// checked with immediate assertions cycle by cycle.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   n_stall, n_busy;

  hazard_if #(.AW(AW), .TW(TW)) hif ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_d(input logic [AW-1:0] rs, input logic [TW-1:0] trs,
                       input logic [AW-1:0] rt, input logic [TW-1:0] trt,
                       input logic [AW-1:0] a3, input logic [TW-1:0] tnew,
                       input logic [1:0] st, input logic md_use);
    hif.D_rs       = rs;
    hif.D_tuse_rs  = trs;
    hif.D_rt       = rt;
    hif.D_tuse_rt  = trt;
    hif.D_a3       = a3;
    hif.D_tnew     = tnew;
    hif.D_md_start = st;
    hif.D_md_use   = md_use;
  endtask

  task automatic idle();
    set_d('0, TUSE_NONE, '0, TUSE_NONE, '0, '0, MD_NONE, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts consecutive stalled cycles for an md consumer held in D.
  task automatic count_md_stall();
    n_stall = 0;
    n_busy  = 0;
    for (int i = 0; i < 40; i++) begin
      if (hif.stall) n_stall++;
      if (hif.md_busy) n_busy++;
      if (!hif.stall) break;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    set_d('0, '0, '0, '0, '0, '0, MD_NONE, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    settle();
    chk("rst_stall",    32'(hif.stall),    0);
    chk("rst_md_busy",  32'(hif.md_busy),  0);
    chk("rst_fwd_D_rs", 32'(hif.fwd_D_rs), 0);
    chk("rst_fwd_D_rt", 32'(hif.fwd_D_rt), 0);
    chk("rst_fwd_E_rs", 32'(hif.fwd_E_rs), 0);
    chk("rst_fwd_E_rt", 32'(hif.fwd_E_rt), 0);
    drain();

    // lw a3=8 tnew=2, then addu rs=8 tuse=1
    set_d('0, TUSE_NONE, '0, TUSE_NONE, 5'd8, 2'd2, MD_NONE, 1'b0);
    settle();
    chk("lw_issue_stall", 32'(hif.stall), 0);
    tick();
    set_d(5'd8, 2'd1, '0, TUSE_NONE, 5'd9, 2'd1, MD_NONE, 1'b0);
    settle();
    chk("lw_use_stall1", 32'(hif.stall), 1);
    tick();
    settle();
    chk("lw_use_stall_clear", 32'(hif.stall), 0);
    chk("lw_use_fwd_D_rs",    32'(hif.fwd_D_rs), 0);
    tick();
    idle();
    settle();
    chk("lw_use_fwd_E_rs", 32'(hif.fwd_E_rs), 3);
    chk("lw_use_fwd_E_rt", 32'(hif.fwd_E_rt), 0);
    drain();

    // addu a3=3 tnew=1, then beq rs=3 tuse=0
    set_d('0, TUSE_NONE, '0, TUSE_NONE, 5'd3, 2'd1, MD_NONE, 1'b0);
    tick();
    set_d(5'd3, 2'd0, '0, TUSE_NONE, '0, '0, MD_NONE, 1'b0);
    settle();
    chk("beq_stall1", 32'(hif.stall), 1);
    tick();
    settle();
    chk("beq_stall_clear", 32'(hif.stall), 0);
    chk("beq_fwd_D_rs",    32'(hif.fwd_D_rs), 2);
    tick();
    idle();
    settle();
    chk("beq_fwd_E_rs", 32'(hif.fwd_E_rs), 3);
    drain();

    // tnew equal to tuse is not a hazard; unread operand never stalls
    set_d('0, TUSE_NONE, '0, TUSE_NONE, 5'd8, 2'd2, MD_NONE, 1'b0);
    tick();
    set_d(5'd8, 2'd2, 5'd8, TUSE_NONE, '0, '0, MD_NONE, 1'b0);
    settle();
    chk("eq_tuse_stall",  32'(hif.stall), 0);
    chk("eq_tuse_fwd_D",  32'(hif.fwd_D_rs), 0);
    drain();

    // register 0 never matches
    set_d('0, TUSE_NONE, '0, TUSE_NONE, '0, 2'd1, MD_NONE, 1'b0);
    tick();
    set_d('0, 2'd0, '0, 2'd0, '0, '0, MD_NONE, 1'b0);
    settle();
    chk("r0_stall",    32'(hif.stall),    0);
    chk("r0_fwd_D_rs", 32'(hif.fwd_D_rs), 0);
    chk("r0_fwd_D_rt", 32'(hif.fwd_D_rt), 0);
    tick();
    idle();
    settle();
    chk("r0_fwd_E_rs", 32'(hif.fwd_E_rs), 0);
    chk("r0_fwd_E_rt", 32'(hif.fwd_E_rt), 0);
    drain();

    // M and W both write 5 with tnew=0: youngest wins
    set_d('0, TUSE_NONE, '0, TUSE_NONE, 5'd5, 2'd0, MD_NONE, 1'b0);
    tick();
    tick();
    set_d(5'd5, 2'd0, 5'd5, 2'd0, '0, '0, MD_NONE, 1'b0);
    settle();
    chk("young_stall",    32'(hif.stall),    0);
    chk("young_fwd_D_rs", 32'(hif.fwd_D_rs), 1);
    chk("young_fwd_D_rt", 32'(hif.fwd_D_rt), 1);
    tick();
    idle();
    settle();
    chk("young_fwd_E_rs", 32'(hif.fwd_E_rs), 2);
    chk("young_fwd_E_rt", 32'(hif.fwd_E_rt), 2);
    drain();

    // mult then mfhi
    set_d('0, TUSE_NONE, '0, TUSE_NONE, '0, '0, MD_MULT, 1'b1);
    settle();
    chk("mult_issue_stall", 32'(hif.stall), 0);
    tick();
    set_d('0, TUSE_NONE, '0, TUSE_NONE, '0, '0, MD_NONE, 1'b1);
    count_md_stall();
    chk("mult_stall_cycles", 32'(n_stall), 5);
    chk("mult_busy_cycles",  32'(n_busy),  5);
    chk("mult_mfhi_issue",   32'(hif.stall), 0);
    tick();
    idle();

    // div then mfhi
    set_d('0, TUSE_NONE, '0, TUSE_NONE, '0, '0, MD_DIV, 1'b1);
    settle();
    chk("div_issue_stall", 32'(hif.stall), 0);
    tick();
    set_d('0, TUSE_NONE, '0, TUSE_NONE, '0, '0, MD_NONE, 1'b1);
    count_md_stall();
    chk("div_stall_cycles", 32'(n_stall), 10);
    chk("div_busy_cycles",  32'(n_busy),  10);
    chk("div_mfhi_issue",   32'(hif.stall), 0);
    tick();
    idle();

    // second mult while busy waits, then reloads the counter
    set_d('0, TUSE_NONE, '0, TUSE_NONE, '0, '0, MD_MULT, 1'b1);
    tick();
    count_md_stall();
    chk("mult2_stall_cycles", 32'(n_stall), 5);
    tick();
    idle();
    settle();
    chk("mult2_reload_busy", 32'(hif.md_busy), 1);
    repeat (6) tick();
    settle();
    chk("mult2_done_busy", 32'(hif.md_busy), 0);

    // reset aborts a busy divide and a pending register hazard
    set_d('0, TUSE_NONE, '0, TUSE_NONE, '0, '0, MD_DIV, 1'b1);
    tick();
    idle();
    tick();
    set_d('0, TUSE_NONE, '0, TUSE_NONE, 5'd8, 2'd2, MD_NONE, 1'b0);
    tick();
    set_d(5'd8, 2'd0, '0, TUSE_NONE, '0, '0, MD_NONE, 1'b1);
    settle();
    chk("pre_rst_stall",   32'(hif.stall),   1);
    chk("pre_rst_md_busy", 32'(hif.md_busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("post_rst_stall",    32'(hif.stall),    0);
    chk("post_rst_md_busy",  32'(hif.md_busy),  0);
    chk("post_rst_fwd_D_rs", 32'(hif.fwd_D_rs), 0);
    tick();
    idle();
    settle();
    chk("post_rst_fwd_E_rs", 32'(hif.fwd_E_rs), 0);
    chk("post_rst_md_idle",  32'(hif.md_busy),  0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
